// File: rtl/uart_pkg.sv
// uart_pkg: parity mode constants, receiver FSM encoding and baud divider helper
package uart_pkg;
  localparam int UART_CHECK_NONE = 0;
  localparam int UART_CHECK_ODD = 1;
  localparam int UART_CHECK_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os) > 1 ? clk_hz / (baud * os) : 1;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks (clk, rst_n active-low sync, restart realigns phase -> tick)
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n || restart || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (i_clk, i_rst_n, i_uart_rx -> data/valid/ready handshake, parity/frame/overrun flags, busy)
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK = 50_000_000,
  parameter int P_UART_BAUDRATE = 115200,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK = 0,
  parameter int P_OVERSAMPLE = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
  output logic                         o_user_rx_valid,
  input  logic                         i_user_rx_ready,
  output logic                         o_parity_err,
  output logic                         o_frame_err,
  output logic                         o_overrun,
  output logic                         o_busy
);
  localparam int DIV = calc_div(P_SYSTEM_CLK, P_UART_BAUDRATE, P_OVERSAMPLE);
  localparam int OW = $clog2(P_OVERSAMPLE);
  localparam int BW = $clog2(P_UART_DATA_WIDTH);
  localparam logic [OW-1:0] S0 = OW'(P_OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] S1 = OW'(P_OVERSAMPLE / 2);
  localparam logic [OW-1:0] S2 = OW'(P_OVERSAMPLE / 2 + 1);
  state_t state;
  logic rx_m, rx_s, rx_p, tick, v0, v1, stop_cnt, per, fer;
  logic fall, wrap, s_last, vote, done;
  logic [OW-1:0] os_cnt, os_nxt;
  logic [BW-1:0] bit_cnt;
  logic [P_UART_DATA_WIDTH-1:0] sh;
  assign fall = state == IDLE && rx_p && !rx_s;
  assign os_nxt = os_cnt == OW'(P_OVERSAMPLE - 1) ? '0 : os_cnt + 1'b1;
  assign wrap = tick && os_nxt == '0;
  assign s_last = tick && os_nxt == S2;
  assign vote = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign done = state == STOP && s_last && stop_cnt == 1'(P_UART_STOP_WIDTH - 1);
  assign o_busy = state != IDLE;
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .restart(fall),
    .tick(tick)
  );
  always_ff @(posedge i_clk)
    if (!i_rst_n) {rx_p, rx_s, rx_m} <= '1;
    else {rx_p, rx_s, rx_m} <= {rx_s, rx_m, i_uart_rx};
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      state <= IDLE;
      os_cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      {v0, v1, per, fer} <= '0;
      sh <= '0;
      o_user_rx_data <= '0;
      {o_user_rx_valid, o_parity_err, o_frame_err, o_overrun} <= '0;
    end else begin
      o_overrun <= 1'b0;
      if (done) begin
        if (!o_user_rx_valid || i_user_rx_ready)
          {o_user_rx_data, o_user_rx_valid, o_parity_err, o_frame_err} <= {sh, 1'b1, per, fer | ~vote};
        else o_overrun <= 1'b1;
      end else if (i_user_rx_ready) o_user_rx_valid <= 1'b0;
      if (tick && os_nxt == S0) v0 <= rx_s;
      if (tick && os_nxt == S1) v1 <= rx_s;
      if (state != IDLE && tick) os_cnt <= os_nxt;
      case (state)
        IDLE: if (fall) begin
          state <= START;
          os_cnt <= '0;
          bit_cnt <= '0;
          stop_cnt <= 1'b0;
          {per, fer} <= '0;
        end
        START: if (s_last && vote) state <= IDLE;
          else if (wrap) state <= DATA;
        DATA: begin
          if (s_last) sh <= {vote, sh[P_UART_DATA_WIDTH-1:1]};
          if (wrap) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(P_UART_DATA_WIDTH - 1)) state <= P_UART_CHECK != UART_CHECK_NONE ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (s_last) per <= (^sh ^ vote) != (P_UART_CHECK == UART_CHECK_ODD);
          if (wrap) state <= STOP;
        end
        STOP: begin
          if (s_last && !vote) fer <= 1'b1;
          if (done) state <= IDLE;
          else if (wrap) stop_cnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed checks of uart_rx_os in 8N1, 8E1, 8O1 and 8N2 configurations
module tb_uart_rx_os;
  logic clk = 1'b0, rst_n, rx, ready;
  logic [7:0] d [4];
  logic v [4], pe [4], fe [4], ov [4], bz [4];
  int vectors = 0, miscompares = 0, nrx = 0, nerr = 0;
  bit sweep_on = 1'b0;
  logic [7:0] rxq [128];
  logic [7:0] expq [100];
  logic [7:0] b;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_rx_os #(
      .P_SYSTEM_CLK(16_000_000),
      .P_UART_BAUDRATE(1_000_000),
      .P_UART_DATA_WIDTH(8),
      .P_UART_STOP_WIDTH(g == 3 ? 2 : 1),
      .P_UART_CHECK(g == 1 ? 2 : g == 2 ? 1 : 0),
      .P_OVERSAMPLE(16)
    ) u_dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_uart_rx(rx),
      .o_user_rx_data(d[g]),
      .o_user_rx_valid(v[g]),
      .i_user_rx_ready(ready),
      .o_parity_err(pe[g]),
      .o_frame_err(fe[g]),
      .o_overrun(ov[g]),
      .o_busy(bz[g])
    );
  end
  always @(negedge clk)
    if (sweep_on) begin
      if (v[3] && ready && nrx < 128) begin
        rxq[nrx] = d[3];
        nrx++;
        if (pe[3] || fe[3]) nerr++;
      end
      if (ov[3]) nerr++;
    end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bits(input logic [15:0] bits, input int n, input int per);
    int pos = 0, nxt;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      nxt = pos + per;
      repeat (nxt / 100 - pos / 100) @(negedge clk);
      pos = nxt;
    end
  endtask
  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 16'(d[0]), 16'h0);
    chk("rst_valid", 16'(v[0]), 16'h0);
    chk("rst_perr", 16'(pe[0]), 16'h0);
    chk("rst_ferr", 16'(fe[0]), 16'h0);
    chk("rst_ovr", 16'(ov[0]), 16'h0);
    chk("rst_busy", 16'(bz[0]), 16'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_bits({8'hA5, 1'b0}, 9, 1600);
    rx = 1'b1;
    repeat (11) @(negedge clk);
    chk("a5_valid_early", 16'(v[0]), 16'h0);
    @(negedge clk);
    chk("a5_valid", 16'(v[0]), 16'h1);
    chk("a5_data", 16'(d[0]), 16'h00A5);
    chk("a5_perr", 16'(pe[0]), 16'h0);
    chk("a5_ferr", 16'(fe[0]), 16'h0);
    repeat (20) @(negedge clk);
    chk("a5_hold_valid", 16'(v[0]), 16'h1);
    chk("a5_hold_data", 16'(d[0]), 16'h00A5);
    pulse_ready();
    chk("a5_valid_clr", 16'(v[0]), 16'h0);
    chk("a5_idle", 16'(bz[0]), 16'h0);
    do_reset();
    send_bits({1'b1, 1'b0, 8'h03, 1'b0}, 11, 1600);
    repeat (5) @(negedge clk);
    chk("even_p0_valid", 16'(v[1]), 16'h1);
    chk("even_p0_data", 16'(d[1]), 16'h0003);
    chk("even_p0_perr", 16'(pe[1]), 16'h0);
    chk("even_p0_ferr", 16'(fe[1]), 16'h0);
    chk("odd_p0_data", 16'(d[2]), 16'h0003);
    chk("odd_p0_perr", 16'(pe[2]), 16'h1);
    pulse_ready();
    send_bits({1'b1, 1'b1, 8'h03, 1'b0}, 11, 1600);
    repeat (5) @(negedge clk);
    chk("even_p1_valid", 16'(v[1]), 16'h1);
    chk("even_p1_data", 16'(d[1]), 16'h0003);
    chk("even_p1_perr", 16'(pe[1]), 16'h1);
    chk("odd_p1_valid", 16'(v[2]), 16'h1);
    chk("odd_p1_perr", 16'(pe[2]), 16'h0);
    do_reset();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy", 16'(bz[0]), 16'h1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_idle", 16'(bz[0]), 16'h0);
    chk("glitch_valid", 16'(v[0]), 16'h0);
    send_bits({1'b0, 8'h55, 1'b0}, 10, 1600);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("ferr_valid", 16'(v[0]), 16'h1);
    chk("ferr_data", 16'(d[0]), 16'h0055);
    chk("ferr_flag", 16'(fe[0]), 16'h1);
    chk("ferr_perr", 16'(pe[0]), 16'h0);
    pulse_ready();
    rx = 1'b0;
    repeat (640) @(negedge clk);
    chk("break_valid", 16'(v[0]), 16'h1);
    chk("break_data", 16'(d[0]), 16'h0);
    chk("break_ferr", 16'(fe[0]), 16'h1);
    pulse_ready();
    repeat (100) @(negedge clk);
    chk("break_once", 16'(v[0]), 16'h0);
    chk("break_idle", 16'(bz[0]), 16'h0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    do_reset();
    send_bits({1'b1, 8'h11, 1'b0}, 10, 1600);
    send_bits({8'h22, 1'b0}, 9, 1600);
    rx = 1'b1;
    repeat (11) @(negedge clk);
    chk("ovr_held_data", 16'(d[0]), 16'h0011);
    @(negedge clk);
    chk("ovr_pulse", 16'(ov[0]), 16'h1);
    chk("ovr_keep_data", 16'(d[0]), 16'h0011);
    chk("ovr_keep_valid", 16'(v[0]), 16'h1);
    @(negedge clk);
    chk("ovr_pulse_end", 16'(ov[0]), 16'h0);
    repeat (5) @(negedge clk);
    do_reset();
    send_bits({1'b1, 8'h11, 1'b0}, 10, 1600);
    send_bits({8'h22, 1'b0}, 9, 1600);
    rx = 1'b1;
    repeat (11) @(negedge clk);
    chk("rdy_old_data", 16'(d[0]), 16'h0011);
    pulse_ready();
    chk("rdy_no_ovr", 16'(ov[0]), 16'h0);
    chk("rdy_new_data", 16'(d[0]), 16'h0022);
    chk("rdy_new_valid", 16'(v[0]), 16'h1);
    @(negedge clk);
    chk("rdy_valid_hold", 16'(v[0]), 16'h1);
    repeat (5) @(negedge clk);
    send_bits({8'h7E, 1'b0}, 5, 1600);
    chk("mid_busy", 16'(bz[0]), 16'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_data", 16'(d[0]), 16'h0);
    chk("mid_rst_valid", 16'(v[0]), 16'h0);
    chk("mid_rst_busy", 16'(bz[0]), 16'h0);
    chk("mid_rst_ferr", 16'(fe[0]), 16'h0);
    chk("mid_rst_ovr", 16'(ov[0]), 16'h0);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_bits({1'b1, 8'h3C, 1'b0}, 10, 1600);
    repeat (5) @(negedge clk);
    chk("after_rst_valid", 16'(v[0]), 16'h1);
    chk("after_rst_data", 16'(d[0]), 16'h003C);
    chk("after_rst_ferr", 16'(fe[0]), 16'h0);
    do_reset();
    ready = 1'b1;
    sweep_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom);
      expq[i] = b;
      send_bits({2'b11, b, 1'b0}, 11, i < 50 ? 1552 : 1648);
    end
    rx = 1'b1;
    repeat (40) @(negedge clk);
    sweep_on = 1'b0;
    chk("sweep_count", 16'(nrx), 16'd100);
    chk("sweep_errors", 16'(nerr), 16'd0);
    for (int i = 0; i < 100; i++) chk($sformatf("sweep_byte%0d", i), 16'(rxq[i]), 16'(expq[i]));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
